// File: rtl/conv3x3_mac_array.sv
// conv3x3_mac_array: NK parallel 3x3 convolution MACs fed one pixel column per handshake,
// with runtime-loadable weights/biases, per-row zero-pad masking and optional ReLU.
module conv3x3_mac_array #(
   parameter int DW    = 16,
   parameter int WW    = 16,
   parameter int ACC_W = 40,
   parameter int NK    = 2,
   parameter int FB    = 16,
   parameter int KSW   = (NK > 1) ? $clog2(NK) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wt_we,
   input  logic [KSW-1:0]      wt_sel,
   input  logic [3:0]          wt_addr,
   input  logic [WW-1:0]       wt_data,
   input  logic                relu_en,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3*DW-1:0]     in_col,
   input  logic [2:0]          in_mask,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NK*ACC_W-1:0] out_data
);
   logic [WW-1:0]       w_q [NK][9];
   logic [ACC_W-1:0]    bias_q [NK];
   logic [ACC_W-1:0]    acc_q [NK];
   logic [ACC_W-1:0]    acc_d [NK];
   logic [1:0]          col_q, col_d;
   logic [NK*ACC_W-1:0] out_q, out_d;
   logic                out_valid_q, out_valid_d;
   logic                accept, last;
   logic [ACC_W-1:0]    bias_ext;

   // Exact unsigned-pixel x signed-weight product, sign-extended to the accumulator width.
   function automatic logic [ACC_W-1:0] mul(input logic [DW-1:0] p, input logic [WW-1:0] w);
      logic signed [DW+WW:0] a, b, prod;
      a = {{(WW+1){1'b0}}, p};
      b = {{(DW+1){w[WW-1]}}, w};
      prod = a * b;
      return {{(ACC_W-DW-WW-1){prod[DW+WW]}}, prod};
   endfunction

   assign in_ready    = !out_valid_q || out_ready;
   assign accept      = in_valid && in_ready;
   assign last        = col_q == 2'd2;
   assign col_d       = last ? 2'd0 : col_q + 2'd1;
   assign bias_ext    = {{(ACC_W-WW){wt_data[WW-1]}}, wt_data} << FB;
   assign out_valid_d = (accept && last) ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
   assign out_valid   = out_valid_q;
   assign out_data    = out_q;

   always_comb begin
      out_d = '0;
      for (int k = 0; k < NK; k++) begin
         acc_d[k] = (col_q == 2'd0) ? bias_q[k] : acc_q[k];
         for (int r = 0; r < 3; r++)
            acc_d[k] = acc_d[k] + (in_mask[r] ? mul(in_col[r*DW +: DW], w_q[k][4'(3*r) + {2'b00, col_q}]) : '0);
         out_d[k*ACC_W +: ACC_W] = (relu_en && acc_d[k][ACC_W-1]) ? '0 : acc_d[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NK; k++) begin
            bias_q[k] <= '0;
            acc_q[k]  <= '0;
            for (int t = 0; t < 9; t++) w_q[k][t] <= '0;
         end
         col_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         for (int k = 0; k < NK; k++) begin
            if (wt_we && wt_sel == KSW'(k)) begin
               for (int t = 0; t < 9; t++)
                  if (wt_addr == 4'(t)) w_q[k][t] <= wt_data;
               if (wt_addr == 4'd9) bias_q[k] <= bias_ext;
            end
            if (accept) acc_q[k] <= acc_d[k];
         end
         if (accept) col_q <= col_d;
         if (accept && last) out_q <= out_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_conv3x3_mac_array.sv
// tb_conv3x3_mac_array: directed vector table, hand-written corner sequences and
// randomized windows checked against an arithmetic convolution model.
module tb_conv3x3_mac_array;
   logic        clk = 1'b0, reset = 1'b1, wt_we = 1'b0, relu_en = 1'b0;
   logic [0:0]  wt_sel = '0;
   logic [3:0]  wt_addr = '0;
   logic [15:0] wt_data = '0;
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid;
   logic [47:0] in_col = '0;
   logic [2:0]  in_mask = '0;
   logic [79:0] out_data;
   int          n_pass = 0, n_tot = 0;
   shortint     mw [2][9];
   shortint     mb [2];
   longint      pc [3][3];
   logic [2:0]  mc [3];
   logic        rl;
   logic [79:0] hold_v;

   typedef struct {
      logic [15:0] w0, w1, b0, b1, pix;
      logic [2:0]  m0, m1, m2;
      logic        relu;
      logic [39:0] e0, e1;
   } vec_t;
   vec_t tv[6];

   conv3x3_mac_array #(.DW(16), .WW(16), .ACC_W(40), .NK(2), .FB(16)) dut (
      .clk(clk), .reset(reset), .wt_we(wt_we), .wt_sel(wt_sel), .wt_addr(wt_addr),
      .wt_data(wt_data), .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
      .in_col(in_col), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data));

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int k, input int a, input logic [15:0] d);
      wt_we = 1'b1; wt_sel = 1'(k); wt_addr = 4'(a); wt_data = d;
      tick;
      wt_we = 1'b0;
      if (a < 9) mw[k][a] = d;
      else if (a == 9) mb[k] = d;
   endtask

   task automatic load_k(input int k, input logic [15:0] t, input logic [15:0] b);
      for (int i = 0; i < 9; i++) wr(k, i, t);
      wr(k, 9, b);
   endtask

   task automatic set_col(input logic [15:0] p0, p1, p2, input logic [2:0] m, input logic r);
      in_valid = 1'b1; in_col = {p2, p1, p0}; in_mask = m; relu_en = r;
   endtask

   task automatic send_col(input logic [15:0] p0, p1, p2, input logic [2:0] m, input logic r);
      int n = 0;
      set_col(p0, p1, p2, m, r);
      while (!in_ready && n < 20) begin tick; n++; end
      if (n == 20) chk("in_ready_timeout", 96'(in_ready), 96'(1));
      tick;
      in_valid = 1'b0;
   endtask

   task automatic zero_model;
      for (int k = 0; k < 2; k++) begin
         mb[k] = 0;
         for (int t = 0; t < 9; t++) mw[k][t] = 0;
      end
   endtask

   function automatic logic [39:0] model(input int k, input logic r);
      longint s = longint'(mb[k]) * 65536;
      logic [39:0] res;
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 3; i++)
            if (mc[c][i]) s += longint'(mw[k][3*i+c]) * pc[c][i];
      res = s[39:0];
      return (r && res[39]) ? 40'h0 : res;
   endfunction

   initial begin
      tv[0] = '{16'h1, 16'hFFFF, 16'h0, 16'h0, 16'h2, 3'b111, 3'b111, 3'b111, 1'b0, 40'h12, 40'hFF_FFFF_FFEE};
      tv[1] = '{16'h1, 16'hFFFF, 16'h0, 16'h0, 16'h2, 3'b111, 3'b111, 3'b111, 1'b1, 40'h12, 40'h0};
      tv[2] = '{16'h1, 16'hFFFF, 16'h1, 16'h0, 16'h2, 3'b111, 3'b111, 3'b111, 1'b0, 40'h1_0012, 40'hFF_FFFF_FFEE};
      tv[3] = '{16'h1, 16'hFFFF, 16'h0, 16'h0, 16'h2, 3'b000, 3'b010, 3'b000, 1'b0, 40'h2, 40'hFF_FFFF_FFFE};
      tv[4] = '{16'h1, 16'hFFFF, 16'h0, 16'h0, 16'h2, 3'b000, 3'b111, 3'b111, 1'b0, 40'hC, 40'hFF_FFFF_FFF4};
      tv[5] = '{16'h1, 16'h3, 16'h0, 16'h8000, 16'h2, 3'b111, 3'b111, 3'b111, 1'b0, 40'h12, 40'hFF_8000_0036};
      zero_model;
      tick; tick;
      chk("reset_state", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 80'h0});
      reset = 1'b0;
      tick;

      for (int i = 0; i < 6; i++) begin
         load_k(0, tv[i].w0, tv[i].b0);
         load_k(1, tv[i].w1, tv[i].b1);
         send_col(tv[i].pix, tv[i].pix, tv[i].pix, tv[i].m0, tv[i].relu);
         chk("vec_mid_valid", 96'(out_valid), 96'(0));
         send_col(tv[i].pix, tv[i].pix, tv[i].pix, tv[i].m1, tv[i].relu);
         send_col(tv[i].pix, tv[i].pix, tv[i].pix, tv[i].m2, tv[i].relu);
         chk($sformatf("vec%0d", i), {out_valid, out_data}, {1'b1, tv[i].e1, tv[i].e0});
      end

      // Backpressure: result held, column offered but refused, in_ready combinational on out_ready
      load_k(1, 16'hFFFF, 16'h0);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) send_col(16'h2, 16'h2, 16'h2, 3'b111, 1'b0);
      chk("bp_result", {out_valid, out_data}, {1'b1, 40'hFF_FFFF_FFEE, 40'h12});
      set_col(16'h7, 16'h7, 16'h7, 3'b111, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_hold", {in_ready, out_valid, out_data}, {1'b0, 1'b1, 40'hFF_FFFF_FFEE, 40'h12});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 96'(in_ready), 96'(1));
      tick;
      chk("bp_cleared", 96'(out_valid), 96'(0));

      // Overlap: six back-to-back columns, tap 0 of k0 rewritten as window 2 starts
      for (int i = 0; i < 6; i++) begin
         set_col(16'h2, 16'h2, 16'h2, 3'b111, 1'b0);
         if (i == 3) begin wt_we = 1'b1; wt_sel = 1'b0; wt_addr = 4'd0; wt_data = 16'h5; end
         tick;
         wt_we = 1'b0;
         if (i == 2 || i == 5)
            chk($sformatf("ovl_res%0d", i), {out_valid, out_data}, {1'b1, 40'hFF_FFFF_FFEE, 40'h12});
         else
            chk($sformatf("ovl_valid%0d", i), 96'(out_valid), 96'(0));
      end
      in_valid = 1'b0;
      mw[0][0] = 5;
      for (int c = 0; c < 3; c++) send_col(16'h2, 16'h2, 16'h2, 3'b111, 1'b0);
      chk("new_weight", {out_valid, out_data}, {1'b1, 40'hFF_FFFF_FFEE, 40'h1A});

      // Reset mid-window discards partial sums, weights and biases
      send_col(16'h9, 16'h9, 16'h9, 3'b111, 1'b0);
      send_col(16'h9, 16'h9, 16'h9, 3'b111, 1'b0);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      zero_model;
      chk("midrst_state", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 80'h0});
      send_col(16'h2, 16'h2, 16'h2, 3'b111, 1'b0);
      chk("midrst_c0", 96'(out_valid), 96'(0));
      send_col(16'h2, 16'h2, 16'h2, 3'b111, 1'b0);
      chk("midrst_c1", 96'(out_valid), 96'(0));
      send_col(16'h2, 16'h2, 16'h2, 3'b111, 1'b0);
      chk("midrst_res", {out_valid, out_data}, {1'b1, 80'h0});
      load_k(0, 16'h1, 16'h0);
      for (int c = 0; c < 3; c++) send_col(16'h2, 16'h2, 16'h2, 3'b111, 1'b0);
      chk("midrst_reload", {out_valid, out_data}, {1'b1, 40'h0, 40'h12});

      // Randomized windows against the arithmetic model
      for (int w = 0; w < 25; w++) begin
         for (int k = 0; k < 2; k++)
            for (int a = 0; a < 10; a++)
               if ($urandom_range(0, 2) == 0) wr(k, a, 16'($urandom));
         wr(int'($urandom_range(0, 1)), int'($urandom_range(10, 15)), 16'($urandom));
         for (int c = 0; c < 3; c++) begin
            repeat ($urandom_range(0, 2)) tick;
            for (int i = 0; i < 3; i++) pc[c][i] = longint'($urandom_range(0, 65535));
            mc[c] = 3'($urandom);
            rl = 1'($urandom);
            send_col(16'(pc[c][0]), 16'(pc[c][1]), 16'(pc[c][2]), mc[c], rl);
         end
         hold_v = {model(1, rl), model(0, rl)};
         chk($sformatf("rnd%0d", w), {out_valid, out_data}, {1'b1, hold_v});
         out_ready = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            tick;
            chk("rnd_hold", {out_valid, out_data}, {1'b1, hold_v});
         end
         out_ready = 1'b1;
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/conv3x3_mac_array.md
# conv3x3_mac_array

Parametrised 3x3 convolution multiply-accumulate engine for the image-convolution datapath. It runs NK kernels in parallel over one 3x3 window, fed one pixel column (three rows) per handshake. Kernel weights and biases are runtime-loadable. Border zero-padding is a per-row, per-column mask. An optional ReLU is applied at the output. It sits between the pixel fetch/address controller and the layer-0 result writer.

## Interface
- DW, 16: pixel width; unsigned.
- WW, 16: weight width; two's complement.
- ACC_W, 40: accumulator and result width; two's complement.
- NK, 2: number of parallel kernels (1..8).
- FB, 16: bias left-shift, aligning the bias with the product fraction point.
- KSW, $clog2(NK) (min 1): kernel-select width.
- Reset is synchronous and active-high on `reset`. The clock is `clk`.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- wt_we  in  1  weight/bias write strobe.
- wt_sel  in  KSW  target kernel index.
- wt_addr  in  4  0..8 = tap (row*3+col); 9 = bias; 10..15 = ignored.
- wt_data  in  WW  weight value, or bias value before shift.
- relu_en  in  1  clamp negative results to 0; sampled when the third column is accepted.
- in_valid  in  1  column valid.
- in_ready  out  1  column accepted when in_valid && in_ready.
- in_col  in  3*DW  row0 = [DW-1:0], row1, row2.
- in_mask  in  3  per-row enable; 0 = zero-pad that row's pixel.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  NK*ACC_W  kernel k result at [k*ACC_W +: ACC_W].

## Operation
- Storage: NK×9 weight registers (WW bits) and NK bias registers (ACC_W bits).
  - On wt_we with wt_addr ≤ 8: w[wt_sel][wt_addr] <= wt_data.
  - On wt_we with wt_addr = 9: bias[wt_sel] <= sign_ext(wt_data) << FB.
  - wt_sel ≥ NK or wt_addr ≥ 10: write is ignored.
- Column counter col ∈ {0,1,2}; advances on each accepted column and wraps 2→0.
- Partial sum per accepted column c, per kernel k: p_k = Σ_r in_mask[r] ? w[k][3r+c]·pix_r : 0.
  - Each product is unsigned DW × signed WW, exact, then sign-extended to ACC_W.
- Accumulation:
  - col = 0: acc_k <= bias[k] + p_k.
  - col = 1: acc_k <= acc_k + p_k.
  - col = 2: result_k = acc_k + p_k. It is loaded into out_data with ReLU applied if relu_en, and out_valid is set.
  - All sums wrap modulo 2^ACC_W. There is no saturation.
- An all-zero in_mask is a fully padded column: it is accepted, counts toward the window, and contributes 0.
- in_ready = !out_valid || out_ready. An accumulator never overwrites an unconsumed result.
- out_valid is cleared on out_ready unless a new result loads in the same cycle. On that simultaneous event the new result wins and out_valid stays 1.
- Weight write in the same cycle as an accepted column: that column uses the old value. The new value applies from the next cycle.
- Reset values:
  - weights 0, biases 0, acc 0, col 0.
  - out_data 0, out_valid 0, in_ready 1 (out_valid is 0).
- Reset mid-window discards the partial window. The next accepted column is col 0.

## Timing
- Latency: out_valid and out_data are registered, asserted the cycle after the col=2 column is accepted.
- Throughput: one window per 3 accepted columns. With out_ready held 1 the engine accepts a column every cycle, so there is no bubble.
- Backpressure: out_data and out_valid hold stable while out_valid && !out_ready.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid.

## Test plan
- Basic sum: NK=2, FB=16. Load k0 taps = 1 and bias 0; load k1 taps = 16'hFFFF and bias 0. Send 3 columns of pixels = 2, in_mask = 3'b111, relu_en=0. Expect one cycle later out_data k0 = 40'h00_0000_0012 and k1 = 40'hFF_FFFF_FFEE.
- ReLU and bias:
  - Same as basic sum with relu_en=1: expect k1 = 0.
  - With k0 bias wt_data = 1: expect k0 = 40'h00_0001_0012.
- Padding: k0 taps = 1, pixels = 2. Middle column uses in_mask = 3'b010; outer columns use 3'b000. Expect k0 = 2.
  - Left-edge window: first column mask 3'b000, others 3'b111. Expect k0 = 12.
- Backpressure: out_ready=0 after the first window. Expect in_ready = 0 and out_data unchanged for 5 cycles. Raise out_ready and expect in_ready = 1 that same cycle.
- Overlap: stream 6 columns with out_ready = 1. Expect out_valid on cycle 4 and cycle 7 with no stall.
  - Mid-stream weight write on the cycle a column is accepted: that column's result uses the old weight.
- Reset mid-window: accept 2 columns, pulse reset, then send 3 fresh columns. Expect a single result equal to the fresh window with biases 0 and all weights 0 until reloaded.
